sseg_scan_mux: RTL
==================

// Module: sseg_scan_mux
// PURPOSE
//  Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
//  Holds a loaded multi-digit hex value; each refresh slot selects one digit,
//  drives its nibble on hex_out to the downstream hex-to-segment decoder, and
//  enables that digit's active-low anode. Sits between the counter/load logic
//  and the segment decoder feeding the board cathodes.
// PARAMETERS
//  N_DIGITS     4       number of digits scanned (2..8)
//  REFRESH_DIV  100000  clk cycles per digit slot (100 MHz -> 1 kHz/digit)
//  LZ_BLANK     1       1 = blank leading-zero digits (digit 0 never blanked)
// PORTS
//  clk        in   1           system clock, rising edge
//  reset      in   1           synchronous, active-high
//  load       in   1           1-cycle strobe: capture value_in/dp_in/digit_en
//  value_in   in   4*N_DIGITS  nibble i = digit i (digit 0 = rightmost)
//  dp_in      in   N_DIGITS    decimal point per digit, active-high
//  digit_en   in   N_DIGITS    per-digit enable, 0 = digit forced dark
//  hex_out    out  4           nibble of the currently scanned digit
//  anode_out  out  N_DIGITS    active-low digit select, at most one bit low
//  dp_out     out  1           active-low decimal point of scanned digit
//  frame_out  out  1           1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//  - Reset: prescaler=0, index=0, active regs (value,dp,en)=0, pending=0;
//    anode_out=all 1, hex_out=0, dp_out=1, frame_out=0.
//  - Prescaler counts 0..REFRESH_DIV-1; slot_tick when count==REFRESH_DIV-1.
//    On slot_tick: index <= (index==N_DIGITS-1) ? 0 : index+1.
//  - Frame boundary = slot_tick with index==N_DIGITS-1; frame_out pulses on the
//    cycle index becomes 0.
//  - Load handshake (tear-free): load captures inputs into shadow regs and sets
//    pending. On a frame boundary with pending=1, shadow -> active, pending<=0.
//    load while pending=1: shadow overwritten, last load wins.
//    load on the frame-boundary cycle: value_in/dp_in/digit_en go straight to
//    active, pending<=0 (no extra frame latency).
//  - Outputs are registered: hex_out/anode_out/dp_out reflect index and active
//    regs one cycle after they change.
//  - Digit i dark (anode bit 1, dp_out 1, hex_out still = nibble) when
//    digit_en[i]==0, or LZ_BLANK==1 and i>0 and nibbles i..N_DIGITS-1 all 0.
//  - Otherwise anode_out = ~(1<<index), hex_out = nibble[index], dp_out=~dp[index].
//  - Reset mid-frame: all state returns to reset values next cycle; pending load
//    discarded.
//  - Widths: prescaler $clog2(REFRESH_DIV) bits; index $clog2(N_DIGITS) bits,
//    explicit wrap at N_DIGITS-1 (non-power-of-2 counts safe).
// STRUCTURE
//  - Shared package: SEG_REFRESH_DIV_DEFAULT, SEG_N_DIGITS_DEFAULT, active-low
//    ANODE_OFF constant; reused by decoder and top level.
//  - One sub-module: sseg_refresh_timer (prescaler + index counter, outputs
//    slot_tick, index, frame boundary). Load/shadow, blanking, output regs inline.
// TESTING (bench uses REFRESH_DIV=4, N_DIGITS=4)
//  1 reset held 3 cycles -> anode_out=4'b1111, dp_out=1, frame_out=0 throughout.
//  2 load value_in=16'h12A4, dp_in=0, digit_en=4'hF -> after next frame,
//    anode_out cycles 1110,1101,1011,0111 each 4 clk; hex_out 4,A,2,1.
//  3 load 16'h0007, LZ_BLANK=1 -> digit0 anode low, hex_out=7; digits 1-3 dark;
//    load 16'h0700 -> digits 0,1,2 lit (0,0,7), digit 3 dark.
//  4 load 16'h1111 mid-frame then load 16'h2222 before boundary -> display
//    never shows 1111; shows 2222 from next frame; load on boundary cycle ->
//    new value visible at digit 0 of the immediately following frame.
//  5 dp_in=4'b0100, digit_en=4'b1011 -> dp_out=0 only during digit 2 slot;
//    digit 2 dark (anode 1) is overridden -> dp_out=1, anode_out never 1011.
//  6 reset asserted during digit 2 slot with pending load -> next cycle all
//    outputs at reset values; after release, display shows 0 digits blanked
//    except digit 0 only once a new load completes (active regs = 0, en = 0
//    -> all dark).

Source files
------------

// File: rtl/sseg_scan_mux_pkg.sv
// Shared constants and helpers for the 7-segment scan driver and its neighbours.
package sseg_scan_mux_pkg;

  localparam int SEG_N_DIGITS_DEFAULT    = 4;
  localparam int SEG_REFRESH_DIV_DEFAULT = 100000;
  localparam int SEG_MAX_DIGITS          = 8;

  // Common-anode digits are selected by a low anode, so "all off" is all ones.
  localparam logic [SEG_MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Per-slot view of the digit currently being scanned.
  typedef struct packed {
    logic [3:0] hex;
    logic       dp_n;
    logic       dark;
  } digit_view_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int seg_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// Load bus into the scan driver and the scanned-digit outputs it returns.
interface sseg_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     digit_en;
  logic [3:0]              hex_out;
  logic [N_DIGITS-1:0]     anode_out;
  logic                    dp_out;
  logic                    frame_out;

  modport master (
    output load, value_in, dp_in, digit_en,
    input  hex_out, anode_out, dp_out, frame_out
  );

  modport slave (
    input  load, value_in, dp_in, digit_en,
    output hex_out, anode_out, dp_out, frame_out
  );
endinterface

// File: rtl/sseg_refresh_timer.sv
// Slot prescaler and digit index counter for the scan driver.
module sseg_refresh_timer
  import sseg_scan_mux_pkg::*;
#(
  parameter int N_DIGITS    = SEG_N_DIGITS_DEFAULT,
  parameter int REFRESH_DIV = SEG_REFRESH_DIV_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           slot_tick_o,
  output logic [seg_cnt_w(N_DIGITS)-1:0] index_o,
  output logic                           frame_bnd_o
);

  localparam int PW = seg_cnt_w(REFRESH_DIV);
  localparam int IW = seg_cnt_w(N_DIGITS);

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] index_q, index_d;
  logic          last_digit;

  // Prescaler wraps every REFRESH_DIV cycles; index wraps explicitly at the last digit.
  always_comb begin
    slot_tick_o = (presc_q == PW'(REFRESH_DIV - 1));
    last_digit  = (index_q == IW'(N_DIGITS - 1));
    presc_d     = slot_tick_o ? '0 : presc_q + 1'b1;
    index_d     = index_q;
    if (slot_tick_o) begin
      index_d = last_digit ? '0 : index_q + 1'b1;
    end
    frame_bnd_o = slot_tick_o & last_digit;
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      index_q <= '0;
    end else begin
      presc_q <= presc_d;
      index_q <= index_d;
    end
  end

  assign index_o = index_q;

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
module sseg_scan_mux
  import sseg_scan_mux_pkg::*;
#(
  parameter int N_DIGITS    = SEG_N_DIGITS_DEFAULT,
  parameter int REFRESH_DIV = SEG_REFRESH_DIV_DEFAULT,
  parameter int LZ_BLANK    = 1
) (
  input  logic          clk,
  input  logic          reset,
  sseg_scan_mux_if.slave bus
);

  localparam int IW = seg_cnt_w(N_DIGITS);
  localparam int VW = 4 * N_DIGITS;
  localparam logic [N_DIGITS-1:0] SEL_DIGIT0 = 1;
  localparam logic [N_DIGITS-1:0] ALL_DARK   = ANODE_OFF[N_DIGITS-1:0];

  logic          slot_tick;
  logic          frame_bnd_raw;
  logic          frame_bnd;
  logic [IW-1:0] index;

  sseg_refresh_timer #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .slot_tick_o (slot_tick),
    .index_o     (index),
    .frame_bnd_o (frame_bnd_raw)
  );

  // The boundary is only meaningful on a slot tick; qualify it explicitly.
  assign frame_bnd = slot_tick & frame_bnd_raw;

  logic [VW-1:0]       act_val_q, act_val_d;
  logic [N_DIGITS-1:0] act_dp_q,  act_dp_d;
  logic [N_DIGITS-1:0] act_en_q,  act_en_d;
  logic                pend_q,    pend_d;
  logic [VW-1:0]       sh_val_q;
  logic [N_DIGITS-1:0] sh_dp_q;
  logic [N_DIGITS-1:0] sh_en_q;

  // Tear-free update: active regs only change on a frame boundary, a load on
  // the boundary itself bypasses the shadow so it costs no extra frame.
  always_comb begin
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_en_d  = act_en_q;
    pend_d    = pend_q;
    if (frame_bnd && bus.load) begin
      act_val_d = bus.value_in;
      act_dp_d  = bus.dp_in;
      act_en_d  = bus.digit_en;
      pend_d    = 1'b0;
    end else if (frame_bnd && pend_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      act_en_d  = sh_en_q;
      pend_d    = 1'b0;
    end else if (bus.load) begin
      pend_d    = 1'b1;
    end
  end

  // Active registers and pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_en_q  <= '0;
      pend_q    <= 1'b0;
    end else begin
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_en_q  <= act_en_d;
      pend_q    <= pend_d;
    end
  end

  // Shadow capture; last load before the boundary wins. Contents are only
  // consumed while pending is set, so no reset is needed.
  always_ff @(posedge clk) begin
    if (bus.load) begin
      sh_val_q <= bus.value_in;
      sh_dp_q  <= bus.dp_in;
      sh_en_q  <= bus.digit_en;
    end
  end

  logic [N_DIGITS-1:0] lz_mask;
  logic                upper_zero;
  digit_view_t         view;
  logic [N_DIGITS-1:0] anode_d;

  // Blanking and selection for the digit at the current index. lz_mask[i] is
  // set when digit i and every digit to its left hold zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (act_val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = upper_zero;
    end
    view.hex  = act_val_q[4*int'(index) +: 4];
    view.dark = !act_en_q[index] ||
                ((LZ_BLANK != 0) && (index != '0) && lz_mask[index]);
    view.dp_n = view.dark ? 1'b1 : ~act_dp_q[index];
    anode_d   = view.dark ? ALL_DARK : ~(SEL_DIGIT0 << index);
  end

  logic [3:0]          hex_q;
  logic [N_DIGITS-1:0] anode_q;
  logic                dp_q;
  logic                frame_q;

  // Registered display outputs; frame pulse lands as the index returns to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q   <= 4'h0;
      anode_q <= ALL_DARK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      hex_q   <= view.hex;
      anode_q <= anode_d;
      dp_q    <= view.dp_n;
      frame_q <= frame_bnd;
    end
  end

  assign bus.hex_out   = hex_q;
  assign bus.anode_out = anode_q;
  assign bus.dp_out    = dp_q;
  assign bus.frame_out = frame_q;

endmodule
